// File: rtl/cnt_seg_pkg.sv
// Shared types and constants for the two-digit multiplexed 7-segment scanner.
// Segment bit order is {g,f,e,d,c,b,a}, active high.
package cnt_seg_pkg;

  typedef enum logic {
    ONES = 1'b0,
    TENS = 1'b1
  } digit_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [1:0] AN_ONES = 2'b01;
  localparam logic [1:0] AN_TENS = 2'b10;

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to 7-segment decode. Non-BCD inputs blank the digit.
module seg7_dec
  import cnt_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Lookup of the digit pattern
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cnt_seg_scan.sv
// Two-digit multiplexed 7-segment scanner for a 4-bit count (0..15).
// Each digit is enabled for SCAN_DIV clocks; the value is latched once per
// frame so both digits always come from the same sample.
// Build option: define LZ_BLANK_EN to blank a leading-zero tens digit.
//
// state | meaning
// ------+-------------------------------------------
// ONES  | ones digit enabled (an = 01)
// TENS  | tens digit enabled (an = 10); leaving it latches cnt_in
module cnt_seg_scan
  import cnt_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tick;
  digit_t        state, state_next;
  logic [3:0]    disp_val, disp_next;
  logic          tens_d;
  logic [3:0]    ones_d;
  logic [3:0]    dec_in;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_next;
  logic [1:0]    an_next;

  assign tick = (div_cnt == DIV_MAX);

  // Prescaler: 0..SCAN_DIV-1 then wrap
  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  // Digit state register
  always_ff @(posedge clk) begin
    if (rst) state <= ONES;
    else state <= state_next;
  end

  // Next digit state and frame capture of the count
  always_comb begin
    state_next = state;
    disp_next  = disp_val;
    if (tick) begin
      case (state)
        ONES:    state_next = TENS;
        TENS: begin
          state_next = ONES;
          disp_next  = cnt_in;
        end
        default: state_next = ONES;
      endcase
    end
  end

  // Captured display value
  always_ff @(posedge clk) begin
    if (rst) disp_val <= 4'd0;
    else disp_val <= disp_next;
  end

  // Split the upcoming value into digits and pick the one to be shown, so
  // seg and an are registered together with the state change.
  always_comb begin
    tens_d  = (disp_next >= 4'd10);
    ones_d  = tens_d ? (disp_next - 4'd10) : disp_next;
    dec_in  = (state_next == TENS) ? {3'b000, tens_d} : ones_d;
    an_next = (state_next == TENS) ? AN_TENS : AN_ONES;
`ifdef LZ_BLANK_EN
    seg_next = ((state_next == TENS) && !tens_d) ? SEG_BLANK : dec_seg;
`else
    seg_next = dec_seg;
`endif
  end

  seg7_dec u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  // Output registers: segments and anodes change on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_0;
      an  <= AN_ONES;
    end else begin
      seg <= seg_next;
      an  <= an_next;
    end
  end

endmodule

// File: doc/cnt_seg_scan.md
CNT_SEG_SCAN -- requirements
Module: cnt_seg_scan

Interface
REQ-001 Parameter SHALL be: SCAN_DIV, default 1000, clk cycles each digit is displayed; legal range 2..1048576.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all logic on its rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, synchronous, active-high reset.
REQ-004 Port cnt_in SHALL be: input, 4 bits, unsigned count from the up/down counter stage (0..15).
REQ-005 Port seg SHALL be: output, 7 bits, active-high segments {g,f,e,d,c,b,a} (seg[0]=a).
REQ-006 Port an SHALL be: output, 2 bits, one-hot active-high digit enable; an[0]=ones, an[1]=tens.

Function
REQ-007 Prescaler div_cnt SHALL count 0..SCAN_DIV-1 and wrap to 0; internal tick SHALL be high for exactly the one cycle in which div_cnt==SCAN_DIV-1.
REQ-008 Digit FSM SHALL have two states, ONES and TENS; on tick, ONES->TENS and TENS->ONES; no other transitions.
REQ-009 On the tick taking TENS->ONES, disp_val SHALL capture cnt_in; disp_val SHALL NOT change at any other time (frame-coherent, no tearing).
REQ-010 tens = (disp_val>=10) ? 1 : 0; ones = disp_val - 10*tens; both SHALL be 0..9 for every 4-bit value.
REQ-011 seg and an SHALL be registered and SHALL update in the same cycle, one cycle after the tick (no ghosting).
REQ-012 an SHALL be 2'b01 in ONES and 2'b10 in TENS; an SHALL always be one-hot, never 00 or 11.
REQ-013 Digit codes SHALL be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-014 Each digit SHALL be shown for exactly SCAN_DIV consecutive cycles; one full frame is 2*SCAN_DIV cycles.
REQ-015 Worst-case latency from a cnt_in change to its display SHALL be 2*SCAN_DIV+1 cycles.
REQ-016 A cnt_in wrap (15->0 or 0->15) SHALL need no special handling; it is displayed as the plain value at the next capture.

Reset
REQ-017 While rst=1 at a clock edge: div_cnt=0, state=ONES, disp_val=0, an=2'b01, seg=0x3F.
REQ-018 Reset asserted mid-frame SHALL take effect at the next edge regardless of state; the first tick after release SHALL occur SCAN_DIV cycles after the first non-reset edge.

Configuration
REQ-019 Macro LZ_BLANK_EN defined: in TENS with tens==0, seg SHALL be 0x00 while an stays 2'b10.
REQ-020 LZ_BLANK_EN undefined: the tens digit SHALL always be shown, so a zero displays as 0x3F.

Structure
REQ-021 Package cnt_seg_pkg SHALL hold the digit-state enum (ONES, TENS), the ten segment constants and SEG_BLANK=0x00.
REQ-022 The combinational BCD-to-7-segment decode SHALL be the sub-module seg7_dec (4-bit in, 7-bit out); cnt_seg_scan SHALL hold all sequential logic.

Verification (SCAN_DIV=4)
REQ-023 rst=1 for 2 cycles, cnt_in=7: during reset an=01, seg=0x3F. Then an=10 with seg=0x00 (LZ_BLANK_EN) or 0x3F (undefined). Next frame an=01, seg=0x07.
REQ-024 cnt_in=13 held: ones phase seg=0x4F; tens phase seg=0x06; each phase exactly 4 cycles.
REQ-025 cnt_in 5->12 during a TENS phase: display stays 5 until the TENS->ONES tick. Then ones seg=0x5B, tens seg=0x06.
REQ-026 cnt_in 15 then 0 (counter wrap): shows 0x6D/0x06, then 0x3F with tens blank or 0x3F per macro.
REQ-027 rst pulsed for 1 cycle mid-TENS: next edge an=01, seg=0x3F; next an change exactly 4 cycles after release.
REQ-028 Over 1000 random cycles with random cnt_in: an always one-hot, and seg always equals the decode of the last captured value for the shown digit.
